// File: rtl/adc_spi_cfg.sv
// adc_spi_cfg -- SPI configuration master for the LTC2151 serial port.
//
// Sends 16-bit mode-0 frames (R/W, A6..A0, D7..D0, MSB first) either for a
// host request or from an external init table walked via tbl_idx.
//
// Optional feature (macro ADC_CFG_VERIFY_EN): every init write is followed by
// a read of the same address; a readback differing from tbl_data sets the
// sticky err flag. Without the macro no verify frames are sent and err is 0.
//
// Ports:
//   CLK_IN, RST_IN            clock, synchronous active-low reset
//   init_start                pulse: run the init table (ignored while busy)
//   tbl_idx / tbl_addr, tbl_data   table index out, entry contents in
//   req_valid/req_ready, req_rw, req_addr, req_wdata   host request
//   rdata, rvalid             host read result (rvalid one-cycle pulse)
//   busy, init_done, err      status
//   ADC_nCS, ADC_SCK, ADC_SDI, ADC_SDO, ADC_PnS   ADC serial port
module adc_spi_cfg #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned NREG    = 5
) (
  input  logic       CLK_IN,
  input  logic       RST_IN,
  input  logic       init_start,
  output logic [3:0] tbl_idx,
  input  logic [6:0] tbl_addr,
  input  logic [7:0] tbl_data,
  input  logic       req_valid,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       req_ready,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       busy,
  output logic       init_done,
  output logic       err,
  output logic       ADC_nCS,
  output logic       ADC_SCK,
  output logic       ADC_SDI,
  input  logic       ADC_SDO,
  output logic       ADC_PnS
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CS_SETUP, S_SHIFT, S_CS_HOLD, S_GAP
  } state_e;

  typedef enum logic [1:0] {
    SRC_HOST, SRC_INIT, SRC_VERIFY
  } src_e;

  // LOAD already has nCS low, so it counts as the first setup cycle.
  localparam logic [8:0] SETUP_LAST = 9'(CLK_DIV - 2);
  localparam logic [8:0] HALF_LAST  = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LAST   = 9'(2 * CLK_DIV - 1);
  localparam logic [3:0] IDX_LAST   = 4'(NREG - 1);

  state_e      state_q;
  src_e        src_q;
  logic [8:0]  div_q;
  logic [3:0]  bit_q;
  logic [15:0] shreg_q;
  logic [7:0]  rx_q;
  logic        rd_q;
  logic [3:0]  idx_q;
  logic        ncs_q;
  logic        sck_q;
  logic        sdi_q;
  logic        busy_q;
  logic        rdy_q;
  logic        rvalid_q;
  logic        done_q;
  logic [7:0]  rdata_q;
`ifdef ADC_CFG_VERIFY_EN
  logic        err_q;
`endif

  logic [15:0] tbl_frame_d;

  always_comb begin
    tbl_frame_d = {1'b0, tbl_addr, tbl_data};
    if (src_q == SRC_VERIFY) begin
      tbl_frame_d = {1'b1, tbl_addr, 8'h00};
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (!RST_IN) begin
      state_q  <= S_IDLE;
      src_q    <= SRC_HOST;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      rx_q     <= '0;
      rd_q     <= 1'b0;
      idx_q    <= '0;
      ncs_q    <= 1'b1;
      sck_q    <= 1'b0;
      sdi_q    <= 1'b0;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
`ifdef ADC_CFG_VERIFY_EN
      err_q    <= 1'b0;
`endif
    end else begin
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (init_start) begin
            src_q   <= SRC_INIT;
            idx_q   <= '0;
`ifdef ADC_CFG_VERIFY_EN
            err_q   <= 1'b0;
`endif
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
            ncs_q   <= 1'b0;
            state_q <= S_LOAD;
          end else if (req_valid && rdy_q) begin
            // Host frame is captured here; table frames are built in LOAD.
            src_q   <= SRC_HOST;
            rd_q    <= req_rw;
            shreg_q <= {req_rw, req_addr, (req_rw ? 8'h00 : req_wdata)};
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
            ncs_q   <= 1'b0;
            state_q <= S_LOAD;
          end else begin
            rdy_q <= 1'b1;
          end
        end

        S_LOAD: begin
          if (src_q != SRC_HOST) begin
            shreg_q <= tbl_frame_d;
          end
          div_q   <= '0;
          state_q <= S_CS_SETUP;
        end

        S_CS_SETUP: begin
          if (div_q == SETUP_LAST) begin
            div_q   <= '0;
            bit_q   <= '0;
            sdi_q   <= shreg_q[15];
            state_q <= S_SHIFT;
          end else begin
            div_q <= div_q + 9'd1;
          end
        end

        S_SHIFT: begin
          if (div_q == HALF_LAST) begin
            div_q <= '0;
            if (!sck_q) begin
              sck_q <= 1'b1;
              // bit_q[3] marks the data half (bits 8..15) of the frame.
              if (bit_q[3]) begin
                rx_q <= {rx_q[6:0], ADC_SDO};
              end
            end else begin
              sck_q <= 1'b0;
              if (bit_q == 4'd15) begin
                sdi_q   <= 1'b0;
                state_q <= S_CS_HOLD;
                if (src_q == SRC_HOST && rd_q) begin
                  rdata_q  <= rx_q;
                  rvalid_q <= 1'b1;
                end
`ifdef ADC_CFG_VERIFY_EN
                if (src_q == SRC_VERIFY && rx_q != tbl_data) begin
                  err_q <= 1'b1;
                end
`endif
              end else begin
                bit_q   <= bit_q + 4'd1;
                shreg_q <= {shreg_q[14:0], 1'b0};
                sdi_q   <= shreg_q[14];
              end
            end
          end else begin
            div_q <= div_q + 9'd1;
          end
        end

        S_CS_HOLD: begin
          if (div_q == HALF_LAST) begin
            div_q   <= '0;
            ncs_q   <= 1'b1;
            state_q <= S_GAP;
          end else begin
            div_q <= div_q + 9'd1;
          end
        end

        S_GAP: begin
          if (div_q == GAP_LAST) begin
            div_q <= '0;
            if (src_q == SRC_HOST) begin
              busy_q  <= 1'b0;
              rdy_q   <= 1'b1;
              state_q <= S_IDLE;
            end
`ifdef ADC_CFG_VERIFY_EN
            else if (src_q == SRC_INIT) begin
              // Read back the entry just written; tbl_idx stays put.
              src_q   <= SRC_VERIFY;
              ncs_q   <= 1'b0;
              state_q <= S_LOAD;
            end
`endif
            else if (idx_q == IDX_LAST) begin
              done_q  <= 1'b1;
              idx_q   <= '0;
              busy_q  <= 1'b0;
              rdy_q   <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              idx_q   <= idx_q + 4'd1;
              src_q   <= SRC_INIT;
              ncs_q   <= 1'b0;
              state_q <= S_LOAD;
            end
          end else begin
            div_q <= div_q + 9'd1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tbl_idx   = idx_q;
  assign req_ready = rdy_q & ~init_start;
  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign busy      = busy_q;
  assign init_done = done_q;
`ifdef ADC_CFG_VERIFY_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif
  assign ADC_nCS   = ncs_q;
  assign ADC_SCK   = sck_q;
  assign ADC_SDI   = sdi_q;
  assign ADC_PnS   = 1'b0;

endmodule

// File: tb/tb_adc_spi_cfg.sv
// tb_adc_spi_cfg -- directed bench for adc_spi_cfg (CLK_DIV=4, NREG=3).
// An ADC slave model with a register map captures each frame; expected
// frames are queued when stimulus is applied and popped at frame end.
module tb_adc_spi_cfg;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned NREG    = 3;
  localparam int unsigned LOW_CYC = 34 * CLK_DIV;
  localparam int unsigned BUSY_CYC = 36 * CLK_DIV;
  localparam int unsigned RV_AT   = 33 * CLK_DIV;

  logic       CLK_IN = 1'b0;
  logic       RST_IN;
  logic       init_start;
  logic [3:0] tbl_idx;
  logic [6:0] tbl_addr;
  logic [7:0] tbl_data;
  logic       req_valid, req_rw;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       req_ready;
  logic [7:0] rdata;
  logic       rvalid, busy, init_done, err;
  logic       ADC_nCS, ADC_SCK, ADC_SDI, ADC_SDO, ADC_PnS;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  regmap[128];
  logic        corrupt = 1'b0;
  logic        abort = 1'b0;

  adc_spi_cfg #(.CLK_DIV(CLK_DIV), .NREG(NREG)) dut (
    .CLK_IN(CLK_IN), .RST_IN(RST_IN), .init_start(init_start),
    .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rdata(rdata),
    .rvalid(rvalid), .busy(busy), .init_done(init_done), .err(err),
    .ADC_nCS(ADC_nCS), .ADC_SCK(ADC_SCK), .ADC_SDI(ADC_SDI),
    .ADC_SDO(ADC_SDO), .ADC_PnS(ADC_PnS)
  );

  always #5 CLK_IN = ~CLK_IN;

  function automatic logic [14:0] entry(input logic [3:0] i);
    case (i)
      4'd0:    entry = {7'h00, 8'h80};
      4'd1:    entry = {7'h01, 8'h00};
      4'd2:    entry = {7'h02, 8'h01};
      default: entry = {7'h7F, 8'hFF};
    endcase
  endfunction

  always_comb {tbl_addr, tbl_data} = entry(tbl_idx);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ADC slave model, evaluated mid-cycle.
  logic        ncs_p = 1'b1, sck_p = 1'b0, sdo_r = 1'b0;
  logic [15:0] sh = '0;
  logic [7:0]  rd_byte = '0;
  logic [3:0]  idx_start = '0;
  int unsigned r = 0, low_cnt = 0;
  assign ADC_SDO = sdo_r;

  always @(negedge CLK_IN) begin
    if (ncs_p && !ADC_nCS) begin
      r = 0;
      low_cnt = 0;
      idx_start = tbl_idx;
    end
    if (!ADC_nCS) begin
      low_cnt++;
      if (!sck_p && ADC_SCK) begin
        sh = {sh[14:0], ADC_SDI};
        r++;
        if (r == 8) rd_byte = (corrupt && sh[6:0] == 7'h01) ? 8'h01 : regmap[sh[6:0]];
      end
    end
    if (!ncs_p && ADC_nCS) begin
      if (abort) begin
        abort = 1'b0;
      end else begin
        chk("frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("frame_bits", sh, exp_q.pop_front());
          chk("frame_sck_count", r, 16);
          chk("ncs_low_cycles", low_cnt, LOW_CYC);
          chk("tbl_idx_stable", tbl_idx, idx_start);
          if (!sh[15]) regmap[sh[14:8]] = sh[7:0];
        end
      end
    end
    if (!ADC_nCS && r >= 8 && r < 16) sdo_r = rd_byte[3'(15 - r)];
    else sdo_r = 1'b0;
    ncs_p = ADC_nCS;
    sck_p = ADC_SCK;
  end

  task automatic wait_ready();
    int unsigned n = 0;
    while (!req_ready && n < 2000) begin
      @(posedge CLK_IN); #1;
      n++;
    end
    chk("ready_wait_bound", n < 2000, 1);
  endtask

  task automatic push_init();
    for (int unsigned i = 0; i < NREG; i++) begin
      logic [14:0] e;
      e = entry(4'(i));
      exp_q.push_back({1'b0, e});
`ifdef ADC_CFG_VERIFY_EN
      exp_q.push_back({1'b1, e[14:8], 8'h00});
`endif
    end
  endtask

  task automatic host_txn(input logic rw, input logic [6:0] a, input logic [7:0] d,
                          input logic poke, output int unsigned n,
                          output int unsigned rv_at, output int unsigned rv_cnt);
    wait_ready();
    req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = d;
    exp_q.push_back({rw, a, (rw ? 8'h00 : d)});
    @(posedge CLK_IN); #1;
    req_valid = 1'b0;
    chk("busy_on_accept", busy, 1);
    chk("ready_low_busy", req_ready, 0);
    n = 0; rv_at = 0; rv_cnt = 0;
    while (busy && n < 5000) begin
      if (rvalid) begin rv_cnt++; rv_at = n; end
      init_start = (poke && n == 40);
      n++;
      @(posedge CLK_IN); #1;
    end
    init_start = 1'b0;
  endtask

  task automatic run_init(output int unsigned dn);
    int unsigned n = 0;
    wait_ready();
    init_start = 1'b1;
    push_init();
    @(posedge CLK_IN); #1;
    init_start = 1'b0;
    chk("err_cleared_on_start", err, 0);
    dn = 0;
    while (busy && n < 20000) begin
      @(posedge CLK_IN); #1;
      n++;
      if (init_done) dn++;
    end
    chk("init_bound", n < 20000, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned n, rv_at, rv_cnt, dn, done_cnt, done_at_acc;
    logic acc_now;
    logic exp_err;
`ifdef ADC_CFG_VERIFY_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    RST_IN = 1'b0; init_start = 1'b0; req_valid = 1'b0; req_rw = 1'b0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 128; i++) regmap[i] = 8'h00;
    regmap[3] = 8'h5C;

    repeat (3) @(posedge CLK_IN); #1;
    chk("rst_pins", {ADC_nCS, ADC_SCK, ADC_SDI, ADC_PnS}, 4'b1000);
    chk("rst_status", {busy, req_ready, rvalid, init_done, err}, 5'b0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_tbl_idx", tbl_idx, 0);
    RST_IN = 1'b1;
    @(posedge CLK_IN); #1;
    chk("ready_after_rst", req_ready, 1);

    // Host write 0x01 <- 0xA5, with an init_start pulse mid-frame to be ignored.
    host_txn(1'b0, 7'h01, 8'hA5, 1'b1, n, rv_at, rv_cnt);
    chk("write_busy_len", n, BUSY_CYC);
    chk("write_no_rvalid", rv_cnt, 0);

    // Host read 0x03, slave returns 0x5C.
    host_txn(1'b1, 7'h03, 8'h00, 1'b0, n, rv_at, rv_cnt);
    chk("read_busy_len", n, BUSY_CYC);
    chk("read_rvalid_count", rv_cnt, 1);
    chk("read_rvalid_cycle", rv_at, RV_AT);
    chk("read_rdata", rdata, 8'h5C);

    // init_start and req_valid together: init first, host after init_done.
    wait_ready();
    init_start = 1'b1;
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 7'h05; req_wdata = 8'h3C;
    #1;
    chk("ready_blocked_by_init", req_ready, 0);
    push_init();
    exp_q.push_back({1'b0, 7'h05, 8'h3C});
    @(posedge CLK_IN); #1;
    init_start = 1'b0;
    chk("busy_init", busy, 1);
    chk("ready_low_init", req_ready, 0);
    n = 0; done_cnt = 0; done_at_acc = 0;
    while ((req_valid || busy) && n < 20000) begin
      if (init_done) begin
        done_cnt++;
        chk("idx_at_done", tbl_idx, 0);
      end
      acc_now = req_valid && req_ready;
      @(posedge CLK_IN); #1;
      n++;
      if (acc_now) begin
        req_valid = 1'b0;
        done_at_acc = done_cnt;
      end
    end
    chk("combo_bound", n < 20000, 1);
    chk("init_done_pulses", done_cnt, 1);
    chk("host_after_init_done", done_at_acc, 1);
    chk("err_clean_init", err, 0);

    // Corrupted readback of entry 1, then a clean init clears err.
    corrupt = 1'b1;
    run_init(dn);
    chk("corrupt_done_pulses", dn, 1);
    chk("err_after_corrupt", err, exp_err);
    repeat (5) @(posedge CLK_IN); #1;
    chk("err_sticky", err, exp_err);
    corrupt = 1'b0;
    run_init(dn);
    chk("clean_done_pulses", dn, 1);
    chk("err_after_clean", err, 0);

    // Reset in the middle of SHIFT aborts the frame.
    wait_ready();
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 7'h03;
    @(posedge CLK_IN); #1;
    req_valid = 1'b0;
    repeat (40) @(posedge CLK_IN); #1;
    chk("mid_shift_ncs", ADC_nCS, 0);
    abort = 1'b1;
    RST_IN = 1'b0;
    rv_cnt = 0;
    @(posedge CLK_IN); #1;
    chk("abort_pins", {ADC_nCS, ADC_SCK}, 2'b10);
    chk("abort_busy", busy, 0);
    repeat (2) begin
      if (rvalid) rv_cnt++;
      @(posedge CLK_IN); #1;
    end
    RST_IN = 1'b1;
    @(posedge CLK_IN); #1;
    if (rvalid) rv_cnt++;
    chk("abort_ready_after_release", req_ready, 1);
    chk("abort_no_rvalid", rv_cnt, 0);

    // Boundary address 0x7F: write 0xFF and read it back.
    host_txn(1'b0, 7'h7F, 8'hFF, 1'b0, n, rv_at, rv_cnt);
    chk("w7f_busy_len", n, BUSY_CYC);
    host_txn(1'b1, 7'h7F, 8'h00, 1'b0, n, rv_at, rv_cnt);
    chk("r7f_rvalid_count", rv_cnt, 1);
    chk("r7f_rdata", rdata, 8'hFF);

    repeat (10) @(posedge CLK_IN); #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
